// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the one-hot select of an N:1 bit mux.
// Each grant is capped at MAX_HOLD accepted transfers whenever another requester is waiting.
module rr_mux_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] data_i,
   input  logic             ready_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic             y_o,
   output logic             y_valid_o,
   output logic             busy_o
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int HC_W  = $clog2(MAX_HOLD + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t           r_state;
   logic [N_REQ-1:0] r_gnt;
   logic [PTR_W-1:0] r_ptr;
   logic [HC_W-1:0]  r_hold_cnt;

   logic [PTR_W-1:0] w_gidx;
   logic             w_busy;
   logic             w_own_req;
   logic             w_others;
   logic             w_xfer;
   logic             w_at_limit;
   logic             w_release;
   logic [N_REQ-1:0] w_pick_idle;
   logic [N_REQ-1:0] w_pick_hand;

   // Requesters strictly above ptr win first; otherwise wrap to the lowest set bit.
   function automatic logic [N_REQ-1:0] f_pick(input logic [N_REQ-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
      logic [N_REQ-1:0] above;
      logic [N_REQ-1:0] masked;
      logic [N_REQ-1:0] cand;
      above  = ({N_REQ{1'b1}} << ptr) << 1;
      masked = req & above;
      cand   = (|masked) ? masked : req;
      return cand & (~cand + N_REQ'(1));
   endfunction

   always_comb begin
      w_gidx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_gnt[i]) w_gidx = PTR_W'(i);
      end
   end

   assign w_busy      = (r_state == ST_GRANT);
   assign w_own_req   = |(req_i & r_gnt);
   assign w_others    = |(req_i & ~r_gnt);
   assign w_xfer      = w_busy & w_own_req & ready_i;
   assign w_at_limit  = (r_hold_cnt == HC_W'(MAX_HOLD - 1));
   assign w_release   = w_busy & (~w_own_req | (w_xfer & w_at_limit & w_others));
   assign w_pick_idle = f_pick(req_i, r_ptr);
   // The releasing grantee sits last in the scan, so a waiting requester always wins.
   assign w_pick_hand = f_pick(req_i, w_gidx);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_ptr      <= PTR_W'(N_REQ - 1);
         r_hold_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req_i) begin
                  r_gnt      <= w_pick_idle;
                  r_hold_cnt <= '0;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_ptr      <= w_gidx;
                  r_hold_cnt <= '0;
                  if (w_others) begin
                     r_gnt <= w_pick_hand;
                  end else begin
                     r_gnt   <= '0;
                     r_state <= ST_IDLE;
                  end
               end else if (w_xfer) begin
                  // Hitting the limit with nobody waiting just restarts the window.
                  r_hold_cnt <= w_at_limit ? '0 : r_hold_cnt + HC_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

   assign gnt_o     = r_gnt;
   assign busy_o    = w_busy;
   assign y_valid_o = w_busy & w_own_req;
   assign y_o       = |(r_gnt & data_i);

   a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(r_gnt));
   a_valid_gnt   : assert property (@(posedge clk_i) disable iff (!rst_ni) y_valid_o |-> (r_gnt != '0));
   a_hold_range  : assert property (@(posedge clk_i) disable iff (!rst_ni) r_hold_cnt < HC_W'(MAX_HOLD));

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-free behavioural round-robin model.
module tb_rr_mux_arbiter;

   localparam int N  = 4;
   localparam int MH = 8;

   logic         clk_i   = 1'b0;
   logic         rst_ni  = 1'b0;
   logic [N-1:0] req_i   = '0;
   logic [N-1:0] data_i  = '0;
   logic         ready_i = 1'b0;
   logic [N-1:0] gnt_o;
   logic         y_o;
   logic         y_valid_o;
   logic         busy_o;

   int checks   = 0;
   int failures = 0;

   rr_mux_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .data_i    (data_i),
      .ready_i   (ready_i),
      .gnt_o     (gnt_o),
      .y_o       (y_o),
      .y_valid_o (y_valid_o),
      .busy_o    (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Model state: grantee index (-1 when idle), last released grantee, transfers in this window.
   int m_g   = -1;
   int m_ptr = N - 1;
   int m_cnt = 0;

   function automatic int pick(input logic [N-1:0] req, input int p);
      for (int k = 1; k <= N; k++) begin
         if (req[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic others_of(input logic [N-1:0] req, input int g);
      return (req & ~(N'(1) << g)) != '0;
   endfunction

   function automatic logic [N-1:0] exp_gnt(input int g);
      return (g < 0) ? '0 : (N'(1) << g);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         m_g   <= -1;
         m_ptr <= N - 1;
         m_cnt <= 0;
      end else if (m_g < 0) begin
         if (req_i != '0) begin
            m_g   <= pick(req_i, m_ptr);
            m_cnt <= 0;
         end
      end else if (!req_i[m_g] ||
                   (ready_i && m_cnt == MH - 1 && others_of(req_i, m_g))) begin
         m_ptr <= m_g;
         m_cnt <= 0;
         m_g   <= others_of(req_i, m_g) ? pick(req_i, m_g) : -1;
      end else if (ready_i) begin
         m_cnt <= (m_cnt + 1) % MH;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      chk("cyc_gnt", 32'(gnt_o), 32'(exp_gnt(m_g)));
      chk("cyc_busy", 32'(busy_o), 32'(m_g >= 0));
      chk("cyc_yvalid", 32'(y_valid_o), 32'((m_g >= 0) && req_i[(m_g < 0) ? 0 : m_g]));
      chk("cyc_y", 32'(y_o), 32'((m_g >= 0) && data_i[(m_g < 0) ? 0 : m_g]));
   end

   task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] d, input logic rd,
                      output logic [N-1:0] g, output logic y, output logic yv,
                      output logic b, output logic [N-1:0] mg);
      @(posedge clk_i);
      #1;
      req_i   = r;
      data_i  = d;
      ready_i = rd;
      @(negedge clk_i);
      g  = gnt_o;
      y  = y_o;
      yv = y_valid_o;
      b  = busy_o;
      mg = exp_gnt(m_g);
   endtask

   task automatic reset_seq(input logic [N-1:0] r, input logic [N-1:0] d, input logic rd);
      @(posedge clk_i);
      #1;
      rst_ni  = 1'b0;
      req_i   = r;
      data_i  = d;
      ready_i = rd;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic rst_pulse();
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #3;
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [N-1:0] g;
      logic [N-1:0] mg;
      logic [N-1:0] r;
      logic         y;
      logic         yv;
      logic         b;

      // Reset held with every requester active.
      rst_ni  = 1'b0;
      req_i   = 4'b1111;
      ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("t1_rst_gnt", 32'(gnt_o), 32'h0);
      chk("t1_rst_yvalid", 32'(y_valid_o), 32'h0);
      chk("t1_rst_busy", 32'(busy_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("t1_idle_before_edge", 32'(gnt_o), 32'h0);

      // Fairness: five grants of exactly MH cycles in order 0,1,2,3,0.
      for (int c = 0; c < 5 * MH; c++) begin
         cyc(4'b1111, 4'($urandom_range(0, 15)), 1'b1, g, y, yv, b, mg);
         chk("t3_gnt", 32'(g), 32'(4'b0001 << ((c / MH) % 4)));
         chk("t3_model", 32'(mg), 32'(4'b0001 << ((c / MH) % 4)));
      end

      // Lone requester keeps the grant past the hold limit.
      reset_seq(4'b0100, 4'b0101, 1'b1);
      for (int c = 0; c < 21; c++) begin
         cyc(4'b0100, 4'b0101, 1'b1, g, y, yv, b, mg);
         chk("t2_gnt", 32'(g), 32'h4);
         chk("t2_y", 32'(y), 32'h1);
         chk("t2_model", 32'(mg), 32'h4);
      end

      // Stall of five cycles stretches the first grant to 13 cycles.
      reset_seq(4'b1111, 4'b0000, 1'b1);
      for (int c = 0; c < 16; c++) begin
         cyc(4'b1111, 4'($urandom_range(0, 15)), (c >= 3 && c <= 7) ? 1'b0 : 1'b1,
             g, y, yv, b, mg);
         chk("t4_gnt", 32'(g), (c <= 12) ? 32'h1 : 32'h2);
         chk("t4_model", 32'(mg), (c <= 12) ? 32'h1 : 32'h2);
      end

      // Grantee 1 drops while 3 waits: direct handoff, busy never falls.
      reset_seq(4'b0010, 4'b0000, 1'b1);
      cyc(4'b0010, 4'b0000, 1'b1, g, y, yv, b, mg);
      chk("t5_gnt0", 32'(g), 32'h2);
      cyc(4'b1010, 4'b0000, 1'b1, g, y, yv, b, mg);
      cyc(4'b1010, 4'b0000, 1'b1, g, y, yv, b, mg);
      chk("t5_gnt2", 32'(g), 32'h2);
      cyc(4'b1000, 4'b0000, 1'b1, g, y, yv, b, mg);
      chk("t5_drop_gnt", 32'(g), 32'h2);
      chk("t5_drop_yvalid", 32'(yv), 32'h0);
      chk("t5_drop_busy", 32'(b), 32'h1);
      cyc(4'b1000, 4'b1000, 1'b1, g, y, yv, b, mg);
      chk("t5_hand_gnt", 32'(g), 32'h8);
      chk("t5_hand_busy", 32'(b), 32'h1);
      chk("t5_hand_y", 32'(y), 32'h1);
      chk("t5_model", 32'(mg), 32'h8);

      // Reset pulse during grant 2 clears the grant at once; pick restarts at 0.
      reset_seq(4'b1111, 4'b0000, 1'b1);
      for (int c = 0; c < 2 * MH + 2; c++) begin
         cyc(4'b1111, 4'b0000, 1'b1, g, y, yv, b, mg);
      end
      chk("t6_pre_gnt", 32'(g), 32'h4);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("t6_async_gnt", 32'(gnt_o), 32'h0);
      chk("t6_async_busy", 32'(busy_o), 32'h0);
      #2;
      rst_ni = 1'b1;
      cyc(4'b1111, 4'b0000, 1'b1, g, y, yv, b, mg);
      chk("t6_restart_gnt", 32'(g), 32'h1);
      chk("t6_model", 32'(mg), 32'h1);

      // Random traffic with sticky requests so hold limits are reached often.
      reset_seq(4'b0000, 4'b0000, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         r = req_i;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
         end
         cyc(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), g, y, yv, b, mg);
         if ($urandom_range(0, 299) == 0) rst_pulse();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
